// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants and state encoding for the RS-232 receiver
package rs232_pkg;

  localparam logic MARK      = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_DIVISOR = 560;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/rs232_sync.sv
// rtl/rs232_sync.sv - two-flop synchroniser on rxd plus previous-level flop for edge detect
module rs232_sync
  import rs232_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rxd,
  output logic rx_s,
  output logic fall
);

  logic r_meta;
  logic r_rx_s;
  logic r_rx_d;

  // Reset to mark so a line already idle never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= MARK;
      r_rx_s <= MARK;
      r_rx_d <= MARK;
    end else begin
      r_meta <= rxd;
      r_rx_s <= r_meta;
      r_rx_d <= r_rx_s;
    end
  end

  assign rx_s = r_rx_s;
  assign fall = r_rx_d & ~r_rx_s;

endmodule

// File: rtl/rs232receive.sv
// rtl/rs232receive.sv - 8N1 LSB-first serial receiver with mid-bit sampling and framing check
module rs232receive
  import rs232_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  parameter int HALF    = DIVISOR / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam logic [15:0] LP_BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [15:0] LP_HALF_LAST = 16'(HALF - 1);
  localparam logic [2:0]  LP_LAST_IDX  = 3'(DATA_BITS - 1);

  logic w_rx_s;
  logic w_fall;

  state_t               r_state;
  logic [15:0]          r_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_valid;
  logic                 r_framing_error;
  logic                 r_busy;

  rs232_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .rx_s  (w_rx_s),
    .fall  (w_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= 16'd0;
      r_bit_idx       <= 3'd0;
      r_shift         <= '0;
      r_data          <= '0;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
      r_cnt           <= r_cnt + 16'd1;
      case (r_state)
        IDLE: begin
          r_cnt <= 16'd0;
          if (w_fall) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          // Line back high at mid start bit means a glitch, not a frame.
          if (r_cnt == LP_HALF_LAST) begin
            r_cnt <= 16'd0;
            if (w_rx_s == START_BIT) begin
              r_state   <= DATA;
              r_bit_idx <= 3'd0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (r_cnt == LP_BIT_LAST) begin
            r_cnt     <= 16'd0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == LP_LAST_IDX) r_state <= STOP;
          end
        end
        STOP: begin
          // Returning to IDLE at mid stop bit leaves half a bit to catch the next start edge.
          if (r_cnt == LP_BIT_LAST) begin
            r_cnt   <= 16'd0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_rx_s == STOP_BIT) begin
              r_data       <= r_shift;
              r_data_valid <= 1'b1;
            end else begin
              r_framing_error <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data          = r_data;
  assign data_valid    = r_data_valid;
  assign framing_error = r_framing_error;
  assign busy          = r_busy;

endmodule

// File: tb/tb_rs232receive.sv
// tb/tb_rs232receive.sv - directed self-checking bench for rs232receive at 16 clocks per bit
module tb_rs232receive;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          n_valid = 0;
  int          n_ferr = 0;
  int          n_overlap = 0;
  int          n_busy_bad = 0;
  logic        prev_busy = 1'b0;
  logic [7:0]  vals[$];
  int          times[$];

  rs232receive #(.DIVISOR(DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .data          (data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid <= n_valid + 1;
      vals.push_back(data);
      times.push_back(cyc);
      if (busy || !prev_busy) n_busy_bad <= n_busy_bad + 1;
    end
    if (framing_error) n_ferr <= n_ferr + 1;
    if (data_valid && framing_error) n_overlap <= n_overlap + 1;
    prev_busy <= busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    hold(stop, DIV);
  endtask

  int v0, f0;

  initial begin
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_ferr", {31'd0, framing_error}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold(1'b1, 2 * DIV);

    // single good frame
    send_byte(8'h41, 1'b1);
    hold(1'b1, DIV);
    check("t1_valid_cnt", n_valid, 1);
    check("t1_data", {24'd0, data}, 32'h41);
    check("t1_strobe_val", {24'd0, vals[0]}, 32'h41);
    check("t1_ferr_cnt", n_ferr, 0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // start-bit glitch then a good frame
    v0 = n_valid;
    hold(1'b0, 3);
    hold(1'b1, 3 * DIV);
    check("t2_glitch_busy", {31'd0, busy}, 32'd0);
    check("t2_glitch_valid", n_valid - v0, 0);
    send_byte(8'hA5, 1'b1);
    hold(1'b1, DIV);
    check("t2_valid_cnt", n_valid - v0, 1);
    check("t2_data", {24'd0, data}, 32'hA5);

    // framing error after a good frame
    v0 = n_valid;
    f0 = n_ferr;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h55, 1'b0);
    hold(1'b1, 2 * DIV);
    check("t3_valid_cnt", n_valid - v0, 1);
    check("t3_ferr_cnt", n_ferr - f0, 1);
    check("t3_data_held", {24'd0, data}, 32'h3C);

    // back-to-back frames
    v0 = n_valid;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h80, 1'b1);
    hold(1'b1, DIV);
    check("t4_valid_cnt", n_valid - v0, 3);
    if (n_valid - v0 == 3) begin
      check("t4_val0", {24'd0, vals[v0]}, 32'h00);
      check("t4_val1", {24'd0, vals[v0 + 1]}, 32'hFF);
      check("t4_val2", {24'd0, vals[v0 + 2]}, 32'h80);
      check("t4_gap01", times[v0 + 1] - times[v0], 160);
      check("t4_gap12", times[v0 + 2] - times[v0 + 1], 160);
    end

    // reset mid-frame
    v0 = n_valid;
    hold(1'b0, DIV);
    hold(1'b1, DIV);
    hold(1'b0, DIV);
    hold(1'b0, DIV / 2);
    reset = 1'b1;
    hold(1'b1, 2);
    reset = 1'b0;
    hold(1'b1, 12 * DIV);
    check("t5_no_valid", n_valid - v0, 0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_data_reset", {24'd0, data}, 32'h00);
    send_byte(8'h12, 1'b1);
    hold(1'b1, DIV);
    check("t5_valid_cnt", n_valid - v0, 1);
    check("t5_data", {24'd0, data}, 32'h12);

    // break: line held low for 40 bit-times
    v0 = n_valid;
    f0 = n_ferr;
    hold(1'b0, 40 * DIV);
    check("t6_break_ferr", n_ferr - f0, 1);
    check("t6_break_busy", {31'd0, busy}, 32'd0);
    hold(1'b1, 2 * DIV);
    send_byte(8'h7E, 1'b1);
    hold(1'b1, DIV);
    check("t6_ferr_cnt", n_ferr - f0, 1);
    check("t6_valid_cnt", n_valid - v0, 1);
    check("t6_data", {24'd0, data}, 32'h7E);

    check("strobe_overlap", n_overlap, 0);
    check("busy_at_strobe", n_busy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
